clock_key_ctrl: RTL and testbench



---
 rtl/clock_key_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_clock_key_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_key_ctrl.sv
// Purpose : front-panel key controller for the alarm-clock compute block (sync, debounce, set-mode FSM).
// Latency : raw key edge -> press event 2+DEBOUNCE_CYCLES cycles; event -> state/pulse outputs +1 cycle.
// Backpressure: none; the compute block consumes every pulse the cycle it is issued.
//
// Ports:
//   CLOCK, resetn                   clock (rising edge) and asynchronous active-low reset
//   btn_mode, btn_adv, btn_alm_en   raw asynchronous active-high keys
//   TEST_MODE                       (only with DEBOUNCE_BYPASS_EN) bypass debounce, short timers
//   set_time, alarm                 levels: setting time / setting alarm
//   hours, minutes                  one-cycle increment pulses
//   toggle                          alarm-enable level
//   mode_state                      current FSM state code
//
// Optional feature macro: DEBOUNCE_BYPASS_EN (adds TEST_MODE input).
module clock_key_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_RATE     = 4,
    parameter int TIMEOUT_CYCLES  = 64
) (
    input  logic       CLOCK,
    input  logic       resetn,
    input  logic       btn_mode,
    input  logic       btn_adv,
    input  logic       btn_alm_en,
`ifdef DEBOUNCE_BYPASS_EN
    input  logic       TEST_MODE,
`endif
    output logic       set_time,
    output logic       alarm,
    output logic       hours,
    output logic       minutes,
    output logic       toggle,
    output logic [2:0] mode_state
);

    localparam logic [2:0] RUN    = 3'd0;
    localparam logic [2:0] TM_HR  = 3'd1;
    localparam logic [2:0] TM_MIN = 3'd2;
    localparam logic [2:0] AL_HR  = 3'd3;
    localparam logic [2:0] AL_MIN = 3'd4;

    // Test mode shortens the timers; size counters for whichever limit is larger.
    localparam int RD_MAX = (REPEAT_DELAY > 2) ? REPEAT_DELAY : 2;
    localparam int TO_MAX = (TIMEOUT_CYCLES > 8) ? TIMEOUT_CYCLES : 8;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RP_W   = $clog2(RD_MAX + 1);
    localparam int TO_W   = $clog2(TO_MAX + 1);

    // After a repeat pulse the counter reloads so the next pulse lands REPEAT_RATE cycles later.
    localparam int RELOAD = (REPEAT_RATE >= REPEAT_DELAY) ? 1 : (REPEAT_DELAY - REPEAT_RATE + 1);

    logic test_mode;
`ifdef DEBOUNCE_BYPASS_EN
    assign test_mode = TEST_MODE;
`else
    assign test_mode = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Synchronise and debounce: bit 0 = mode, bit 1 = adv, bit 2 = alm_en
    // ---------------------------------------------------------------
    logic [2:0]      raw_lvl;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      deb_r;
    logic [2:0]      deb_lvl;
    logic [2:0]      deb_d;
    logic [2:0]      press;
    logic [DB_W-1:0] db_cnt [3];

    assign raw_lvl = {btn_alm_en, btn_adv, btn_mode};
    assign deb_lvl = test_mode ? sync2 : deb_r;

    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            sync1 <= '0;
            sync2 <= '0;
            deb_r <= '0;
            deb_d <= '0;
            press <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw_lvl;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (test_mode) begin
                    // keep the filtered level tracking so leaving test mode is glitch-free
                    deb_r[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else if (sync2[i] == deb_r[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    // this cycle is the DEBOUNCE_CYCLES-th consecutive differing sample
                    deb_r[i]  <= ~deb_r[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
            deb_d <= deb_lvl;
            press <= deb_lvl & ~deb_d;
        end
    end

    logic mode_evt;
    logic adv_evt;
    logic alm_evt;
    logic adv_lvl;

    assign mode_evt = press[0];
    assign adv_evt  = press[1];
    assign alm_evt  = press[2];
    assign adv_lvl  = deb_lvl[1];

    // ---------------------------------------------------------------
    // Set-mode FSM, auto-repeat and inactivity timeout
    // ---------------------------------------------------------------
    logic [2:0]      state;
    logic [2:0]      state_nxt;
    logic [TO_W-1:0] idle_cnt;
    logic [TO_W-1:0] idle_nxt;
    logic [RP_W-1:0] rep_cnt;
    logic [RP_W-1:0] rep_nxt;
    logic [RP_W-1:0] rep_delay;
    logic [RP_W-1:0] rep_reload;
    logic [TO_W-1:0] to_last;
    logic            in_set;
    logic            is_hr;
    logic            is_min;
    logic            pulse;

    always_comb begin
        if (test_mode) begin
            rep_delay  = RP_W'(2);
            rep_reload = RP_W'(2);
            to_last    = TO_W'(7);
        end else begin
            rep_delay  = RP_W'(REPEAT_DELAY);
            rep_reload = RP_W'(RELOAD);
            to_last    = TO_W'(TIMEOUT_CYCLES - 1);
        end
    end

    assign in_set = (state == TM_HR) || (state == TM_MIN) || (state == AL_HR) || (state == AL_MIN);
    assign is_hr  = (state == TM_HR) || (state == AL_HR);
    assign is_min = (state == TM_MIN) || (state == AL_MIN);

    always_comb begin
        state_nxt = state;
        idle_nxt  = '0;
        rep_nxt   = '0;
        pulse     = 1'b0;

        case (state)
            RUN:     if (mode_evt) state_nxt = TM_HR;
            TM_HR:   if (mode_evt) state_nxt = TM_MIN;
            TM_MIN:  if (mode_evt) state_nxt = AL_HR;
            AL_HR:   if (mode_evt) state_nxt = AL_MIN;
            AL_MIN:  if (mode_evt) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase

        // Idle timeout: a held adv key counts as activity, a held mode key does not.
        if (in_set && !mode_evt) begin
            if (adv_evt || adv_lvl) begin
                idle_nxt = '0;
            end else if (idle_cnt == to_last) begin
                state_nxt = RUN;
                idle_nxt  = '0;
            end else begin
                idle_nxt = idle_cnt + 1'b1;
            end
        end

        // Auto-repeat: only a fresh press in the current state arms the counter,
        // so a key held across a mode change stays silent until re-pressed.
        if (in_set && !mode_evt) begin
            if (adv_evt) begin
                pulse   = 1'b1;
                rep_nxt = RP_W'(1);
            end else if (adv_lvl && (rep_cnt != '0)) begin
                if (rep_cnt == rep_delay) begin
                    pulse   = 1'b1;
                    rep_nxt = rep_reload;
                end else begin
                    rep_nxt = rep_cnt + 1'b1;
                end
            end
        end

        if (state_nxt != state) begin
            rep_nxt = '0;
        end
    end

    always_ff @(posedge CLOCK or negedge resetn) begin
        if (!resetn) begin
            state    <= RUN;
            idle_cnt <= '0;
            rep_cnt  <= '0;
            set_time <= 1'b0;
            alarm    <= 1'b0;
            hours    <= 1'b0;
            minutes  <= 1'b0;
            toggle   <= 1'b0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_nxt;
            rep_cnt  <= rep_nxt;
            // Level outputs are derived from the next state so they move with mode_state.
            set_time <= (state_nxt == TM_HR) || (state_nxt == TM_MIN);
            alarm    <= (state_nxt == AL_HR) || (state_nxt == AL_MIN);
            hours    <= pulse && is_hr;
            minutes  <= pulse && is_min;
            toggle   <= toggle ^ alm_evt;
        end
    end

    assign mode_state = state;

endmodule

// File: tb/tb_clock_key_ctrl.sv
// Directed testbench for clock_key_ctrl with default parameters.
// Cycle n is the interval after the n-th rising edge that samples a newly driven input.
module tb_clock_key_ctrl;

    logic       CLOCK;
    logic       resetn;
    logic       btn_mode;
    logic       btn_adv;
    logic       btn_alm_en;
    logic       set_time;
    logic       alarm;
    logic       hours;
    logic       minutes;
    logic       toggle;
    logic [2:0] mode_state;

    int errors;
    int checks;

    clock_key_ctrl dut (
        .CLOCK      (CLOCK),
        .resetn     (resetn),
        .btn_mode   (btn_mode),
        .btn_adv    (btn_adv),
        .btn_alm_en (btn_alm_en),
`ifdef DEBOUNCE_BYPASS_EN
        .TEST_MODE  (1'b0),
`endif
        .set_time   (set_time),
        .alarm      (alarm),
        .hours      (hours),
        .minutes    (minutes),
        .toggle     (toggle),
        .mode_state (mode_state)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    task automatic step();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        btn_mode   = 1'b0;
        btn_adv    = 1'b0;
        btn_alm_en = 1'b0;
        step();
        step();
        resetn = 1'b1;
    endtask

    // 8-cycle press then 8-cycle release: one clean press event.
    task automatic press_btn(input int which);
        if (which == 0) btn_mode = 1'b1;
        else if (which == 1) btn_adv = 1'b1;
        else btn_alm_en = 1'b1;
        for (int i = 0; i < 8; i++) step();
        btn_mode   = 1'b0;
        btn_adv    = 1'b0;
        btn_alm_en = 1'b0;
        for (int i = 0; i < 8; i++) step();
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        resetn     = 1'b0;
        btn_mode   = 1'b0;
        btn_adv    = 1'b0;
        btn_alm_en = 1'b0;
        step();
        obs = {set_time, alarm, hours, minutes, toggle, mode_state};
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL reset_asserted: outputs=%h expected 00", obs);
        end
        step();
        resetn = 1'b1;
        for (int n = 0; n < 100; n++) begin
            step();
            obs = {set_time, alarm, hours, minutes, toggle, mode_state};
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs=%h expected 00", n, obs);
            end
        end
    endtask

    task automatic test_mode_press();
        do_reset();
        btn_mode = 1'b1;
        for (int n = 0; n < 10; n++) begin
            step();
            if (n == 6) begin
                checks++;
                if (mode_state !== 3'd0) begin
                    errors++;
                    $display("FAIL mode_early cycle 6: mode_state=%0d expected 0", mode_state);
                end
            end
            if (n == 7) begin
                checks++;
                if (mode_state !== 3'd1 || set_time !== 1'b1) begin
                    errors++;
                    $display("FAIL mode_enter cycle 7: mode_state=%0d set_time=%b expected 1/1",
                             mode_state, set_time);
                end
            end
        end
        btn_mode = 1'b0;
        for (int n = 0; n < 20; n++) step();
        // 3-cycle glitch must be filtered out
        btn_mode = 1'b1;
        for (int n = 0; n < 3; n++) step();
        btn_mode = 1'b0;
        for (int n = 0; n < 15; n++) step();
        checks++;
        if (mode_state !== 3'd1 || set_time !== 1'b1 || alarm !== 1'b0) begin
            errors++;
            $display("FAIL mode_glitch: mode_state=%0d set_time=%b alarm=%b expected 1/1/0",
                     mode_state, set_time, alarm);
        end
    endtask

    task automatic test_repeat();
        int exp_pc [7];
        int pc [16];
        int np;
        int hr_seen;
        exp_pc = '{7, 23, 27, 31, 35, 39, 43};
        np = 0;
        hr_seen = 0;
        do_reset();
        press_btn(0);
        press_btn(0);
        checks++;
        if (mode_state !== 3'd2) begin
            errors++;
            $display("FAIL repeat_state: mode_state=%0d expected 2", mode_state);
        end
        btn_adv = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (n == 40) btn_adv = 1'b0;
            step();
            if (minutes === 1'b1 && np < 16) begin
                pc[np] = n;
                np++;
            end
            if (hours !== 1'b0) hr_seen++;
        end
        checks++;
        if (np !== 7) begin
            errors++;
            $display("FAIL repeat_count: pulses=%0d expected 7", np);
        end
        for (int i = 0; i < 7; i++) begin
            if (i < np) begin
                checks++;
                if (pc[i] !== exp_pc[i]) begin
                    errors++;
                    $display("FAIL repeat_pulse %0d: cycle=%0d expected %0d", i, pc[i], exp_pc[i]);
                end
            end
        end
        checks++;
        if (hr_seen !== 0) begin
            errors++;
            $display("FAIL repeat_hours: hours high %0d cycles expected 0", hr_seen);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int n = 0; n < 130; n++) begin
            btn_mode = (n < 10);
            btn_adv  = (n >= 51 && n <= 55);
            step();
            if (n == 71 || n == 124) begin
                checks++;
                if (mode_state !== 3'd1) begin
                    errors++;
                    $display("FAIL timeout_hold cycle %0d: mode_state=%0d expected 1", n, mode_state);
                end
            end
            if (n == 57 || n == 58 || n == 59) begin
                checks++;
                if (hours !== (n == 58)) begin
                    errors++;
                    $display("FAIL timeout_adv cycle %0d: hours=%b expected %b", n, hours, (n == 58));
                end
            end
            if (n == 125) begin
                checks++;
                if (mode_state !== 3'd0 || set_time !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_fire cycle 125: mode_state=%0d set_time=%b expected 0/0",
                             mode_state, set_time);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        pulses = 0;
        do_reset();
        press_btn(0);
        btn_mode = 1'b1;
        btn_adv  = 1'b1;
        for (int n = 0; n < 40; n++) begin
            if (n == 8) btn_mode = 1'b0;
            if (n == 30) btn_adv = 1'b0;
            step();
            if (hours !== 1'b0 || minutes !== 1'b0) pulses++;
        end
        checks++;
        if (mode_state !== 3'd2) begin
            errors++;
            $display("FAIL simul_state: mode_state=%0d expected 2", mode_state);
        end
        checks++;
        if (pulses !== 0) begin
            errors++;
            $display("FAIL simul_pulse: pulse cycles=%0d expected 0", pulses);
        end
    endtask

    task automatic test_toggle();
        do_reset();
        press_btn(2);
        checks++;
        if (toggle !== 1'b1) begin
            errors++;
            $display("FAIL toggle_1: toggle=%b expected 1", toggle);
        end
        press_btn(0);
        press_btn(0);
        press_btn(0);
        press_btn(2);
        checks++;
        if (toggle !== 1'b0 || mode_state !== 3'd3 || alarm !== 1'b1) begin
            errors++;
            $display("FAIL toggle_2: toggle=%b mode_state=%0d alarm=%b expected 0/3/1",
                     toggle, mode_state, alarm);
        end
        press_btn(2);
        checks++;
        if (toggle !== 1'b1 || mode_state !== 3'd3) begin
            errors++;
            $display("FAIL toggle_3: toggle=%b mode_state=%0d expected 1/3", toggle, mode_state);
        end
    endtask

    task automatic test_reset_mid_repeat();
        int hcount;
        logic [7:0] obs;
        hcount = 0;
        do_reset();
        press_btn(2);
        press_btn(0);
        btn_adv = 1'b1;
        for (int n = 0; n < 25; n++) begin
            step();
            if (hours === 1'b1) hcount++;
        end
        checks++;
        if (hcount !== 2) begin
            errors++;
            $display("FAIL midrep_pulses: hours pulses=%0d expected 2", hcount);
        end
        btn_mode = 1'b1;
        resetn = 1'b0;
        #1;
        obs = {set_time, alarm, hours, minutes, toggle, mode_state};
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL midrep_reset: outputs=%h expected 00", obs);
        end
        step();
        step();
        resetn = 1'b1;
        hcount = 0;
        for (int n = 0; n < 30; n++) begin
            step();
            if (hours !== 1'b0 || minutes !== 1'b0) hcount++;
            if (n == 6 || n == 7) begin
                checks++;
                if (mode_state !== ((n == 7) ? 3'd1 : 3'd0)) begin
                    errors++;
                    $display("FAIL midrep_rearm cycle %0d: mode_state=%0d expected %0d",
                             n, mode_state, (n == 7) ? 1 : 0);
                end
            end
        end
        checks++;
        if (hcount !== 0) begin
            errors++;
            $display("FAIL midrep_nopulse: pulse cycles=%0d expected 0", hcount);
        end
        btn_mode = 1'b0;
        btn_adv  = 1'b0;
    endtask

    initial begin
        errors     = 0;
        checks     = 0;
        resetn     = 1'b0;
        btn_mode   = 1'b0;
        btn_adv    = 1'b0;
        btn_alm_en = 1'b0;
        test_reset();
        test_mode_press();
        test_repeat();
        test_timeout();
        test_simultaneous();
        test_toggle();
        test_reset_mid_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
